mem_port_arbiter: RTL and testbench

Sequences the processor's single-port unified memory between two requesters: the IF-stage instruction fetch (read-only) and the MEM-stage load/store. It owns the memory handshake and produces per-requester stall signals. The pipeline hazard logic uses these signals to freeze the PC and IF/ID or to hold MEM. A watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_wdog.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arb_wdog.sv
// Saturating watchdog counting BUSY cycles without a memory acknowledge.
// Latency: expired_o is combinational on the cycle the count would reach TIMEOUT.
// Backpressure: none; the counter holds whenever en_i is low.
module mem_arb_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAXV  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear on a new grant, count up while enabled, saturate at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAXV)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This enabled cycle is the TIMEOUT-th one without an acknowledge.
  assign expired_o = en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between fetch and load/store; optional round-robin tie-break via MEM_ARB_RR_EN.
// Latency: grant in IDLE, mem_req next cycle, done pulse one cycle after mem_ack (3-cycle minimum period).
// Backpressure: requesters hold req until done; stalls are combinational; no access is cancelled once started.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          bus_err
);

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d, winner;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic          any_req, tie, grant;
  logic          wd_en, wd_expired;

  assign any_req = if_req | d_req;
  assign tie     = if_req & d_req;
  assign grant   = (state_q == IDLE) && any_req;
  assign wd_en   = (state_q == BUSY) && !mem_ack;

`ifdef MEM_ARB_RR_EN
  // Holds the requester that took the previous tie; reset to data so fetch takes the first tie.
  gnt_e tie_win_q, tie_win_d;

  // Winner selection: on a tie the previous tie winner yields.
  always_comb begin
    tie_win_d = tie_win_q;
    winner    = d_req ? GNT_D : GNT_IF;
    if (tie) begin
      winner = (tie_win_q == GNT_D) ? GNT_IF : GNT_D;
      if (grant) begin
        tie_win_d = winner;
      end
    end
  end

  // Tie-history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_win_q <= GNT_D;
    end else begin
      tie_win_q <= tie_win_d;
    end
  end
`else
  // Winner selection: data belongs to the older instruction, so it wins ties.
  always_comb begin
    winner = d_req ? GNT_D : GNT_IF;
  end
`endif

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (grant),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: an access always runs to RESP, by acknowledge or by watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (mem_ack || wd_expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: done pulses in RESP for the granted side; stalls follow req/done directly.
  always_comb begin
    if_done  = (state_q == RESP) && (gnt_q == GNT_IF);
    d_done   = (state_q == RESP) && (gnt_q == GNT_D);
    if_stall = if_req & ~if_done;
    d_stall  = d_req & ~d_done;
  end

  // Datapath next-state: latch the access on grant, capture or abort it in BUSY.
  always_comb begin
    gnt_d       = gnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    if (grant) begin
      gnt_d     = winner;
      mem_req_d = 1'b1;
      if (winner == GNT_D) begin
        mem_we_d    = d_we;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
      end else begin
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end
    end else if (state_q == BUSY) begin
      if (mem_ack) begin
        mem_req_d = 1'b0;
        if (gnt_q == GNT_D) begin
          d_rdata_d = mem_rdata;
        end else begin
          if_rdata_d = mem_rdata;
        end
      end else if (wd_expired) begin
        mem_req_d = 1'b0;
        bus_err_d = 1'b1;
        if (gnt_q == GNT_D) begin
          d_rdata_d = '0;
        end else begin
          if_rdata_d = '0;
        end
      end
    end
  end

  // Datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario table, hand sequences, randomized scenarios.
// Latency: expectations derived per scenario from arrival cycles and memory wait counts.
// Backpressure: requesters hold req through their done cycle and drop it afterwards.
module tb_mem_port_arbiter;

  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_done, if_stall, d_done, d_stall, mem_req, mem_we, bus_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
  );

  // One scenario: arrival cycles (-1 = absent), busy cycles per access, whether memory acks,
  // operands, and hand-computed done cycles (-1 = no pulse, -2 = not tabulated).
  typedef struct {
    int         arr_if, arr_d;
    int         b_if, b_d;
    bit         ack_if, ack_d;
    logic [7:0] a_if, a_d, wd, r_if, r_d;
    bit         we;
    int         xp_if, xp_d;
  } scn_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       exp_err;
  logic [7:0] exp_if_rd, exp_d_rd;
  bit         rr_if_next;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic scn_t mk(input int ai, input int ad, input int bi, input int bd,
                              input bit ki, input bit kd, input logic [7:0] adi,
                              input logic [7:0] add, input bit we, input logic [7:0] wd,
                              input logic [7:0] ri, input logic [7:0] rd,
                              input int xi, input int xd);
    scn_t s;
    s.arr_if = ai; s.arr_d = ad; s.b_if = bi; s.b_d = bd;
    s.ack_if = ki; s.ack_d = kd; s.a_if = adi; s.a_d = add;
    s.we = we; s.wd = wd; s.r_if = ri; s.r_d = rd; s.xp_if = xi; s.xp_d = xd;
    return s;
  endfunction

  task automatic model_reset();
    exp_err    = 1'b0;
    exp_if_rd  = 8'h00;
    exp_d_rd   = 8'h00;
    rr_if_next = 1'b1;
  endtask

  // Runs one scenario cycle by cycle, starting from IDLE, checking every output each cycle.
  task automatic run_scn(input scn_t s);
    bit if_first, tie;
    int st_if, st_d, dn_if, dn_d, last, obs_if, obs_d;
    bit bz_if, bz_d, xreq;
    tie = (s.arr_if == 0) && (s.arr_d == 0);
    if (s.arr_if < 0)      if_first = 1'b0;
    else if (s.arr_d < 0)  if_first = 1'b1;
    else if (!tie)         if_first = (s.arr_if < s.arr_d);
    else begin
`ifdef MEM_ARB_RR_EN
      if_first   = rr_if_next;
      rr_if_next = !rr_if_next;
`else
      if_first = 1'b0;
`endif
    end
    st_if = -100; st_d = -100; dn_if = -1; dn_d = -1;
    if (if_first) begin
      st_if = 0; dn_if = s.b_if + 1;
      if (s.arr_d >= 0) begin st_d = imax(s.arr_d, dn_if + 1); dn_d = st_d + s.b_d + 1; end
    end else begin
      st_d = 0; dn_d = s.b_d + 1;
      if (s.arr_if >= 0) begin st_if = imax(s.arr_if, dn_d + 1); dn_if = st_if + s.b_if + 1; end
    end
    last = imax(dn_if, dn_d);
    obs_if = -1; obs_d = -1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      if_req  = (s.arr_if >= 0) && (c >= s.arr_if) && (c <= dn_if);
      d_req   = (s.arr_d >= 0) && (c >= s.arr_d) && (c <= dn_d);
      if_addr = s.a_if; d_addr = s.a_d; d_we = s.we; d_wdata = s.wd;
      bz_if = (s.arr_if >= 0) && (c > st_if) && (c <= st_if + s.b_if);
      bz_d  = (s.arr_d >= 0) && (c > st_d) && (c <= st_d + s.b_d);
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      if (bz_if && (c == st_if + s.b_if) && s.ack_if) begin
        mem_ack = 1'b1; mem_rdata = s.r_if;
      end else if (bz_d && (c == st_d + s.b_d) && s.ack_d) begin
        mem_ack = 1'b1; mem_rdata = s.r_d;
      end else if (!bz_if && !bz_d) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (c == dn_if) begin
        exp_if_rd = s.ack_if ? s.r_if : 8'h00;
        if (!s.ack_if) exp_err = 1'b1;
      end
      if (c == dn_d) begin
        exp_d_rd = s.ack_d ? s.r_d : 8'h00;
        if (!s.ack_d) exp_err = 1'b1;
      end
      @(negedge clk);
      xreq = bz_if || bz_d;
      chk("mem_req", mem_req, xreq);
      if (bz_if) begin
        chk("mem_addr_if", mem_addr, s.a_if);
        chk("mem_we_if", mem_we, 1'b0);
      end
      if (bz_d) begin
        chk("mem_addr_d", mem_addr, s.a_d);
        chk("mem_we_d", mem_we, s.we);
        if (s.we) chk("mem_wdata", mem_wdata, s.wd);
      end
      chk("if_done", if_done, (c == dn_if));
      chk("d_done", d_done, (c == dn_d));
      chk("if_stall", if_stall, if_req && (c != dn_if));
      chk("d_stall", d_stall, d_req && (c != dn_d));
      chk("if_rdata", if_rdata, exp_if_rd);
      chk("d_rdata", d_rdata, exp_d_rd);
      chk("bus_err", bus_err, exp_err);
      if (if_done === 1'b1 && obs_if < 0) obs_if = c;
      if (d_done === 1'b1 && obs_d < 0) obs_d = c;
    end
    if (s.xp_if != -2) chk("if_done_cycle", obs_if, s.xp_if);
    if (s.xp_d != -2)  chk("d_done_cycle", obs_d, s.xp_d);
  endtask

  scn_t tbl[8];
  scn_t rs;
  int   xi2, xd2;

  initial begin
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    model_reset();

    // Reset state, before any clock edge and after a few.
    #3;
    chk("rst_mem_req", mem_req, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done, bus_err}, '0);
    chk("rst_rdata", {if_rdata, d_rdata}, '0);
    chk("rst_stall", {if_stall, d_stall}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

`ifdef MEM_ARB_RR_EN
    xi2 = 2; xd2 = 5;
`else
    xi2 = 5; xd2 = 2;
`endif
    tbl[0] = mk( 0, -1, 1, 1, 1, 1, 8'h10, 8'h00, 0, 8'h00, 8'hA5, 8'h00,  2, -1);
    tbl[1] = mk(-1,  0, 1, 3, 1, 1, 8'h00, 8'h20, 1, 8'h3C, 8'h00, 8'h5A, -1,  4);
    tbl[2] = mk( 0,  0, 1, 1, 1, 1, 8'h11, 8'h21, 0, 8'h00, 8'h01, 8'h02, xi2, xd2);
    tbl[3] = mk( 0,  0, 2, 1, 1, 1, 8'h12, 8'h22, 0, 8'h00, 8'h03, 8'h04,  6,  2);
    tbl[4] = mk( 1,  0, 1, 2, 1, 1, 8'h13, 8'h23, 0, 8'h00, 8'h05, 8'h06,  6,  3);
    tbl[5] = mk( 0,  2, 2, 1, 1, 1, 8'h14, 8'h24, 1, 8'h99, 8'h07, 8'h08,  3,  6);
    tbl[6] = mk( 5,  0, 1, 1, 1, 1, 8'h15, 8'h25, 0, 8'h00, 8'h09, 8'h0A,  7,  2);
    tbl[7] = mk( 0, -1, TIMEOUT, 1, 1, 1, 8'h16, 8'h00, 0, 8'h00, 8'h77, 8'h00, TIMEOUT + 1, -1);
    for (int i = 0; i < 8; i++) run_scn(tbl[i]);
    chk("ack_on_last_cycle_no_err", bus_err, 1'b0);

    // Memory never acknowledges: watchdog abort, rdata forced to zero, sticky error.
    run_scn(mk(0, -1, TIMEOUT, 1, 0, 1, 8'h30, 8'h00, 0, 8'h00, 8'hEE, 8'h00, TIMEOUT + 1, -1));
    run_scn(mk(-1, 0, 1, 1, 1, 1, 8'h00, 8'h31, 0, 8'h00, 8'h00, 8'h42, -1, 2));
    chk("bus_err_sticky", bus_err, 1'b1);

    // Randomized scenarios against the schedule model.
    for (int n = 0; n < 120; n++) begin
      int sel, late;
      sel  = $urandom_range(0, 3);
      late = $urandom_range(0, 6);
      rs = mk(0, 0, $urandom_range(1, 4), $urandom_range(1, 4), 1, 1,
              8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
              8'($urandom), 8'($urandom), -2, -2);
      if (sel == 0) rs.arr_d = -1;
      else if (sel == 1) rs.arr_if = -1;
      else if (sel == 2) rs.arr_if = late;
      else rs.arr_d = late;
      if ($urandom_range(0, 9) == 0) begin rs.b_if = TIMEOUT; rs.ack_if = 0; end
      if ($urandom_range(0, 9) == 0) begin rs.b_d = TIMEOUT; rs.ack_d = 0; end
      run_scn(rs);
    end

    // Reset in the middle of an access: mem_req falls at once, no done pulse.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 8'h44; d_req = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_pre_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_if_done", if_done, 1'b0);
    chk("rst_mid_bus_err", bus_err, 1'b0);
    if_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_done", {if_done, d_done, mem_req}, 3'b000);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    run_scn(mk(0, -1, 1, 1, 1, 1, 8'h50, 8'h00, 0, 8'h00, 8'hC3, 8'h00, 2, -1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
